gate_truth_scanner: RTL and testbench
=====================================

GATE_TRUTH_SCANNER -- requirements
Module: gate_truth_scanner

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the cycles each input pair is held before sampling; legal range is 1..15.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  scan request, sampled only in IDLE.
REQ-006 Port expected  input  4  expected truth table, latched when start is accepted.
REQ-007 Port y_in  input  1  output y of the 2-input gate under test.
REQ-008 Port a_out  output  1  drives gate input a.
REQ-009 Port b_out  output  1  drives gate input b.
REQ-010 Port busy  output  1  high while a scan is in progress.
REQ-011 Port done  output  1  one-cycle pulse when a scan completes.
REQ-012 Port table_out  output  4  captured truth table; bit index = {a,b}.
REQ-013 Port match  output  1  table_out equals the latched expected value.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, CAPTURE and FINISH.
REQ-015 In IDLE with start=1, the next edge SHALL: enter SETTLE; set idx=0; load the settle counter with SETTLE_CYCLES; latch expected; clear table_out and match to 0.
REQ-016 a_out SHALL equal idx[1] and b_out SHALL equal idx[0] in SETTLE and CAPTURE; both SHALL be 0 in IDLE and FINISH.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-018 At the end of the single CAPTURE cycle, y_in SHALL be written into table_out[idx].
REQ-019 From CAPTURE: if idx<3, idx SHALL increment, the settle counter SHALL reload, and the FSM SHALL return to SETTLE; if idx==3, the FSM SHALL go to FINISH.
REQ-020 Input order SHALL be {a,b} = 00, 01, 10, 11, with no wrap-around: idx SHALL never advance past 3.
REQ-021 In FINISH: done SHALL be 1 for exactly one cycle; match SHALL be registered as (table_out == latched expected); the next state SHALL be IDLE.
REQ-022 busy SHALL be 1 in SETTLE and CAPTURE, and 0 in IDLE and FINISH.
REQ-023 Latency: if start is accepted at edge 0, done SHALL be high during cycle 1+4*(SETTLE_CYCLES+1), which is cycle 9 for the default.
REQ-024 start SHALL be ignored in SETTLE, CAPTURE and FINISH; a held start SHALL launch a new scan only after the return to IDLE.
REQ-025 table_out and match SHALL hold their values after FINISH until the next accepted start.
REQ-026 Changes on expected after the latch point SHALL NOT affect match.
REQ-027 y_in SHALL be sampled only in CAPTURE; glitches during SETTLE SHALL NOT affect table_out.

Reset
REQ-028 On rst=1 at any clock edge, including mid-scan, the FSM SHALL go to IDLE with idx=0, counter=0, latched expected=0, and a_out, b_out, busy, done, table_out and match all 0.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 A scan interrupted by reset SHALL NOT produce a done pulse.

Verification
REQ-031 AND gate on y_in, expected=4'b1000, SETTLE_CYCLES=1 -> done in cycle 9, table_out=4'b1000, match=1.
REQ-032 XOR gate, expected=4'b0110 -> table_out=4'b0110, match=1; repeat with NOR and expected=4'b0110 -> table_out=4'b0001, match=0.
REQ-033 SETTLE_CYCLES=3, OR gate -> a_out/b_out each held 4 cycles (3 settle + 1 capture), done in cycle 17, table_out=4'b1110.
REQ-034 start pulsed again during SETTLE of idx=2, and expected changed mid-scan -> no restart; single done pulse; match computed against the originally latched value.
REQ-035 rst asserted in CAPTURE of idx=1 -> next cycle all outputs 0, no done pulse; a fresh start then completes a normal scan.
REQ-036 start held high continuously, NAND gate -> back-to-back scans, each producing table_out=4'b0111, one done pulse per scan, one IDLE cycle between scans.

Source files
------------

// File: rtl/gate_truth_scanner.sv
// Sweeps a 2-input gate through {a,b} = 00,01,10,11, records y for each pair
// and compares the captured truth table against an expected pattern.
//
// state   | meaning
// IDLE    | waiting for start, outputs held from last scan
// SETTLE  | drive a/b from idx, wait SETTLE_CYCLES for the gate to settle
// CAPTURE | one cycle, y_in written into table_out[idx]
// FINISH  | done pulse, match registered
module gate_truth_scanner #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] expected,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic [3:0] table_out,
   output logic       match
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] FINISH  = 2'd3;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   logic [1:0] state;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic [3:0] exp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= 2'd0;
         cnt       <= 4'd0;
         exp_q     <= 4'd0;
         table_out <= 4'd0;
         match     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SETTLE;
                  idx       <= 2'd0;
                  cnt       <= SETTLE_LOAD;
                  exp_q     <= expected;
                  table_out <= 4'd0;
                  match     <= 1'b0;
               end
            end
            SETTLE: begin
               // down-counter; terminal count 1 marks the last settle cycle
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               table_out[idx] <= y_in;
               if (idx == 2'd3) begin
                  state <= FINISH;
               end else begin
                  idx   <= idx + 2'd1;
                  cnt   <= SETTLE_LOAD;
                  state <= SETTLE;
               end
            end
            FINISH: begin
               match <= (table_out == exp_q);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state == SETTLE) || (state == CAPTURE);
   assign a_out = busy & idx[1];
   assign b_out = busy & idx[0];
   assign done  = (state == FINISH);

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Two scanners (SETTLE_CYCLES = 1 and 3) share stimulus; a cycle-count model
// predicts every output and directed scans pin latencies and tables.
module tb_gate_truth_scanner;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] expected;
   int         gate;
   logic       glitch;
   logic       chk_en;

   wire  [1:0] y;
   logic [1:0] a_o, b_o, busy_o, done_o, match_o;
   logic [3:0] tbl [2];

   int errors = 0;
   int checks = 0;

   // 0 AND, 1 XOR, 2 NOR, 3 OR, other NAND
   function automatic logic gf(input int g, input logic a, input logic b);
      case (g)
         0:       return a & b;
         1:       return a ^ b;
         2:       return ~(a | b);
         3:       return a | b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // model state, one entry per instance
   int         mt [2] = '{0, 0};
   logic [3:0] mtbl [2] = '{4'd0, 4'd0};
   logic [3:0] mexp [2] = '{4'd0, 4'd0};
   logic       mm [2] = '{1'b0, 1'b0};
   logic [1:0] m_cap = 2'b00;

   logic       s_rst, s_start;
   logic [3:0] s_exp;
   int         s_gate;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         gate_truth_scanner #(.SETTLE_CYCLES(gi == 0 ? 1 : 3)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .expected  (expected),
            .y_in      (y[gi]),
            .a_out     (a_o[gi]),
            .b_out     (b_o[gi]),
            .busy      (busy_o[gi]),
            .done      (done_o[gi]),
            .table_out (tbl[gi]),
            .match     (match_o[gi])
         );
         // glitches injected everywhere except the capture cycle
         assign y[gi] = gf(gate, a_o[gi], b_o[gi]) ^ (glitch & ~m_cap[gi]);
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      s_rst   <= rst;
      s_start <= start;
      s_exp   <= expected;
      s_gate  <= gate;
   end

   // t = cycles since accept: 1..4(S+1) scanning, 4(S+1)+1 is the done cycle
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int s, bz, f, k;
         logic e_busy;
         s  = (i == 0) ? 1 : 3;
         bz = 4 * (s + 1);
         f  = bz + 1;
         if (s_rst) begin
            mt[i] = 0; mtbl[i] = 4'd0; mexp[i] = 4'd0; mm[i] = 1'b0;
         end else if (mt[i] == 0) begin
            if (s_start) begin
               mt[i] = 1; mtbl[i] = 4'd0; mexp[i] = s_exp; mm[i] = 1'b0;
            end
         end else if (mt[i] == f) begin
            mm[i] = (mtbl[i] == mexp[i]);
            mt[i] = 0;
         end else begin
            if ((mt[i] - 1) % (s + 1) == s) begin
               k = (mt[i] - 1) / (s + 1);
               mtbl[i][k] = gf(s_gate, k[1], k[0]);
            end
            mt[i]++;
         end
         e_busy   = (mt[i] >= 1) && (mt[i] <= bz);
         k        = e_busy ? (mt[i] - 1) / (s + 1) : 0;
         m_cap[i] = e_busy && ((mt[i] - 1) % (s + 1) == s);
         if (chk_en) begin
            chk("busy",  i, 32'(busy_o[i]),  32'(e_busy));
            chk("done",  i, 32'(done_o[i]),  32'(mt[i] == f));
            chk("a_out", i, 32'(a_o[i]),     32'(e_busy & k[1]));
            chk("b_out", i, 32'(b_o[i]),     32'(e_busy & k[0]));
            chk("table", i, 32'(tbl[i]),     32'(mtbl[i]));
            chk("match", i, 32'(match_o[i]), 32'(mm[i]));
         end
      end
   end

   // caller is 1 time unit after a posedge with both instances idle
   task automatic scan(input int g, input logic [3:0] e, input logic [3:0] et,
                       input logic em, input int poke, input logic gl);
      int lat [2];
      int nd [2];
      lat = '{-1, -1};
      nd  = '{0, 0};
      gate = g; expected = e; glitch = gl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == poke) begin
            start = 1'b1; expected = ~e;
         end else if (n == poke + 1) begin
            start = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (done_o[i]) begin
               nd[i]++;
               if (lat[i] < 0) lat[i] = n + 1;
            end
         end
      end
      glitch = 1'b0;
      chk("done_cycle", 0, 32'(lat[0]), 32'd9);
      chk("done_cycle", 1, 32'(lat[1]), 32'd17);
      for (int i = 0; i < 2; i++) begin
         chk("done_count",  i, 32'(nd[i]),      32'd1);
         chk("final_table", i, 32'(tbl[i]),     32'(et));
         chk("final_match", i, 32'(match_o[i]), 32'(em));
      end
   endtask

   initial begin
      int nd0, nd1;
      chk_en = 1'b0;
      rst = 1'b1; start = 1'b0; expected = 4'd0; gate = 0; glitch = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; expected = 4'hF;
      @(posedge clk); #1;
      chk("rst_prio_busy", 0, 32'(busy_o), 32'd0);
      chk("reset_table",   0, 32'(tbl[0]), 32'd0);
      chk("reset_match",   0, 32'(match_o), 32'd0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;

      scan(0, 4'b1000, 4'b1000, 1'b1, 0, 1'b1);
      scan(1, 4'b0110, 4'b0110, 1'b1, 0, 1'b0);
      scan(2, 4'b0110, 4'b0001, 1'b0, 0, 1'b0);
      scan(3, 4'b1110, 4'b1110, 1'b1, 0, 1'b0);
      scan(1, 4'b0110, 4'b0110, 1'b1, 4, 1'b0);

      // reset in CAPTURE of idx=1 on the SETTLE_CYCLES=1 instance
      gate = 4; expected = 4'b0111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_a",    0, 32'(a_o[0]),    32'd0);
      chk("pre_rst_b",    0, 32'(b_o[0]),    32'd1);
      chk("pre_rst_busy", 0, 32'(busy_o[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy",  0, 32'(busy_o),  32'd0);
      chk("rst_a",     0, 32'(a_o),     32'd0);
      chk("rst_b",     0, 32'(b_o),     32'd0);
      chk("rst_done",  0, 32'(done_o),  32'd0);
      chk("rst_table", 0, 32'(tbl[0]),  32'd0);
      chk("rst_match", 0, 32'(match_o), 32'd0);
      nd0 = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done_o != 2'b00) nd0++;
      end
      chk("no_done_after_rst", 0, 32'(nd0), 32'd0);
      scan(4, 4'b0111, 4'b0111, 1'b1, 0, 1'b0);

      // start held: back-to-back NAND scans
      gate = 4; expected = 4'b0111; start = 1'b1;
      @(posedge clk); #1;
      nd0 = 0; nd1 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (done_o[0]) nd0++;
         if (done_o[1]) nd1++;
      end
      start = 1'b0;
      chk("held_done_count", 0, 32'(nd0), 32'd3);
      chk("held_done_count", 1, 32'(nd1), 32'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("held_table", 0, 32'(tbl[0]),     32'b0111);
      chk("held_table", 1, 32'(tbl[1]),     32'b0111);
      chk("held_match", 0, 32'(match_o[0]), 32'd1);
      chk("held_match", 1, 32'(match_o[1]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
